// File: rtl/intersection_phase_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : intersection_phase_scheduler_if
// Purpose  : Request inputs and lamp/phase outputs of the phase scheduler.
// Revision : 1.0  initial release
// ============================================================================
interface intersection_phase_scheduler_if;
    logic       emergency;
    logic       ns_car_req;
    logic       ew_car_req;
    logic       ped_req;
    logic       ns_red;
    logic       ns_yellow;
    logic       ns_green;
    logic       ew_red;
    logic       ew_yellow;
    logic       ew_green;
    logic       ped_walk;
    logic       ped_dont_walk;
    logic [2:0] phase;

    modport master (
        output emergency, ns_car_req, ew_car_req, ped_req,
        input  ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
        input  ped_walk, ped_dont_walk, phase
    );

    modport slave (
        input  emergency, ns_car_req, ew_car_req, ped_req,
        output ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
        output ped_walk, ped_dont_walk, phase
    );
endinterface
`default_nettype wire

// File: rtl/intersection_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : intersection_phase_scheduler
// Purpose  : Two-approach intersection plus all-way walk, sequenced by a
//            Moore FSM with one shared down-counter and all-red clearance.
// Revision : 1.0  initial release
// ============================================================================
module intersection_phase_scheduler #(
    parameter int GREEN_TIME  = 30,
    parameter int YELLOW_TIME = 5,
    parameter int ALLRED_TIME = 2,
    parameter int WALK_TIME   = 5,
    parameter int CNT_W       = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    intersection_phase_scheduler_if.slave bus
);

    localparam logic [2:0] c_ALL_RED   = 3'd0;
    localparam logic [2:0] c_NS_GREEN  = 3'd1;
    localparam logic [2:0] c_NS_YELLOW = 3'd2;
    localparam logic [2:0] c_EW_GREEN  = 3'd3;
    localparam logic [2:0] c_EW_YELLOW = 3'd4;
    localparam logic [2:0] c_PED_WALK  = 3'd5;
    localparam logic [2:0] c_EMERG     = 3'd6;

    localparam logic [CNT_W-1:0] c_GREEN_LD  = CNT_W'(GREEN_TIME - 1);
    localparam logic [CNT_W-1:0] c_YELLOW_LD = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] c_ALLRED_LD = CNT_W'(ALLRED_TIME - 1);
    localparam logic [CNT_W-1:0] c_WALK_LD   = CNT_W'(WALK_TIME - 1);
    localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_next_count;
    logic             r_ns_pend;
    logic             r_ew_pend;
    logic             r_ped_pend;
    logic             r_last_dir_ew;
    logic             r_last_ped;
    logic             w_done;
    logic             w_ped_wins;
    logic             w_enter_ns;
    logic             w_enter_ew;
    logic             w_enter_ped;

    assign w_done = (r_count == '0);
    // A served walk yields to any waiting car before walking again
    assign w_ped_wins = r_ped_pend & ~(r_last_ped & (r_ns_pend | r_ew_pend));

    always_comb begin
        w_next_state = r_state;
        w_next_count = w_done ? '0 : r_count - c_ONE;
        case (r_state)
            c_ALL_RED: begin
                if (w_done) begin
                    if (w_ped_wins) begin
                        w_next_state = c_PED_WALK;
                        w_next_count = c_WALK_LD;
                    end else if (r_ns_pend && (!r_ew_pend || r_last_dir_ew)) begin
                        w_next_state = c_NS_GREEN;
                        w_next_count = c_GREEN_LD;
                    end else if (r_ew_pend) begin
                        w_next_state = c_EW_GREEN;
                        w_next_count = c_GREEN_LD;
                    end
                end
            end
            c_NS_GREEN, c_EW_GREEN: begin
                if (w_done) begin
                    w_next_state = (r_state == c_NS_GREEN) ? c_NS_YELLOW : c_EW_YELLOW;
                    w_next_count = c_YELLOW_LD;
                end
            end
            c_NS_YELLOW, c_EW_YELLOW, c_PED_WALK: begin
                if (w_done) begin
                    w_next_state = c_ALL_RED;
                    w_next_count = c_ALLRED_LD;
                end
            end
            c_EMERG: begin
                w_next_state = c_ALL_RED;
                w_next_count = c_ALLRED_LD;
            end
            default: begin
                w_next_state = c_ALL_RED;
                w_next_count = c_ALLRED_LD;
            end
        endcase
        if (bus.emergency) begin
            w_next_state = c_EMERG;
            w_next_count = '0;
        end
    end

    assign w_enter_ns  = (w_next_state == c_NS_GREEN) && (r_state != c_NS_GREEN);
    assign w_enter_ew  = (w_next_state == c_EW_GREEN) && (r_state != c_EW_GREEN);
    assign w_enter_ped = (w_next_state == c_PED_WALK) && (r_state != c_PED_WALK);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ALL_RED;
            r_count       <= c_ALLRED_LD;
            r_ns_pend     <= 1'b0;
            r_ew_pend     <= 1'b0;
            r_ped_pend    <= 1'b0;
            r_last_dir_ew <= 1'b1;
            r_last_ped    <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_count    <= w_next_count;
            // A request on the entry edge is not ignored, so it re-arms the bit
            r_ns_pend  <= (r_ns_pend  & ~w_enter_ns)  | (bus.ns_car_req & (r_state != c_NS_GREEN));
            r_ew_pend  <= (r_ew_pend  & ~w_enter_ew)  | (bus.ew_car_req & (r_state != c_EW_GREEN));
            r_ped_pend <= (r_ped_pend & ~w_enter_ped) | (bus.ped_req    & (r_state != c_PED_WALK));
            if (w_enter_ns) begin
                r_last_dir_ew <= 1'b0;
            end else if (w_enter_ew) begin
                r_last_dir_ew <= 1'b1;
            end
            if (w_enter_ped) begin
                r_last_ped <= 1'b1;
            end else if (w_enter_ns || w_enter_ew) begin
                r_last_ped <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.ns_red    = 1'b0;
        bus.ns_yellow = 1'b0;
        bus.ns_green  = 1'b0;
        bus.ew_red    = 1'b0;
        bus.ew_yellow = 1'b0;
        bus.ew_green  = 1'b0;
        bus.ped_walk  = 1'b0;
        case (r_state)
            c_NS_GREEN:  begin bus.ns_green  = 1'b1; bus.ew_red = 1'b1; end
            c_NS_YELLOW: begin bus.ns_yellow = 1'b1; bus.ew_red = 1'b1; end
            c_EW_GREEN:  begin bus.ew_green  = 1'b1; bus.ns_red = 1'b1; end
            c_EW_YELLOW: begin bus.ew_yellow = 1'b1; bus.ns_red = 1'b1; end
            c_PED_WALK:  begin bus.ns_red = 1'b1; bus.ew_red = 1'b1; bus.ped_walk = 1'b1; end
            c_EMERG:     begin end
            default:     begin bus.ns_red = 1'b1; bus.ew_red = 1'b1; end
        endcase
    end

    assign bus.ped_dont_walk = ~bus.ped_walk;
    assign bus.phase         = r_state;

endmodule
`default_nettype wire
